// File: rtl/spi_ctrl_pkg.sv
// Shared constants, register map and state encoding for the SPI configuration path.
// The peripheral and the benches use the same address constants.
package spi_ctrl_pkg;

  localparam int FRAME_W   = 16;
  localparam int WRITE_BIT = 15;

  localparam logic [6:0] OUT_7_0  = 7'd1;
  localparam logic [6:0] OUT_15_8 = 7'd2;
  localparam logic [6:0] PWM_7_0  = 7'd3;
  localparam logic [6:0] PWM_15_8 = 7'd4;
  localparam logic [6:0] DUTY     = 7'd5;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} spi_state_e;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [6:0] addr,
                                                     input logic [7:0] data);
    return {1'b1, addr, data};
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Two-way round-robin arbiter; the last-grant pointer moves only on an accepted handshake.
module spi_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_q, last_d;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = last_q ? 2'b01 : 2'b10;
    last_d = accept ? grant[1] : last_q;
  end

  // Pointer resets to 1 so requester 0 wins the first contested round.
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/spi_config_master.sv
// SPI mode-0 register-write master: arbitrates two requesters and shifts one
// 16-bit write frame per accepted request, then holds nCS high for a minimum gap.
module spi_config_master
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [6:0] req_addr0,
  input  logic [6:0] req_addr1,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] req_ready,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI
);

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

  spi_state_e         state_q, state_d;
  logic [FRAME_W-2:0] shreg_q, shreg_d;
  logic [7:0]         hcnt_q, hcnt_d;
  logic [4:0]         bit_q, bit_d;
  logic [7:0]         gap_q, gap_d;
  logic               id_q, id_d;
  logic               ncs_q, ncs_d;
  logic               sclk_q, sclk_d;
  logic               copi_q, copi_d;
  logic               done_q, done_d;
  logic               done_id_q, done_id_d;

  logic [1:0]         grant;
  logic               hs;
  logic [FRAME_W-1:0] frame;

  spi_rr_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (req_valid),
    .accept(hs),
    .grant (grant)
  );

  assign req_ready = (state_q == IDLE) ? grant : 2'b00;
  assign hs        = |(req_valid & req_ready);
  assign frame     = grant[1] ? build_frame(req_addr1, req_data1)
                              : build_frame(req_addr0, req_data0);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    hcnt_d    = hcnt_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    id_d      = id_q;
    ncs_d     = ncs_q;
    sclk_d    = sclk_q;
    copi_d    = copi_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    case (state_q)
      IDLE: begin
        ncs_d  = 1'b1;
        sclk_d = 1'b0;
        copi_d = 1'b0;
        if (hs) begin
          shreg_d = frame[FRAME_W-2:0];
          copi_d  = frame[WRITE_BIT];
          id_d    = grant[1];
          ncs_d   = 1'b0;
          hcnt_d  = 8'd0;
          bit_d   = 5'd0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (hcnt_q == HALF_LAST) begin
          hcnt_d  = 8'd0;
          sclk_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      SHIFT: begin
        if (hcnt_q == HALF_LAST) begin
          hcnt_d = 8'd0;
          if (sclk_q) begin
            // Data moves on the falling edge so it is stable across the next rise.
            sclk_d  = 1'b0;
            copi_d  = shreg_q[FRAME_W-2];
            shreg_d = {shreg_q[FRAME_W-3:0], 1'b0};
          end else if (bit_q == 5'd15) begin
            state_d   = GAP;
            ncs_d     = 1'b1;
            copi_d    = 1'b0;
            done_d    = 1'b1;
            done_id_d = id_q;
            gap_d     = 8'd0;
          end else begin
            bit_d  = bit_q + 5'd1;
            sclk_d = 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      hcnt_q    <= 8'd0;
      bit_q     <= 5'd0;
      gap_q     <= 8'd0;
      id_q      <= 1'b0;
      ncs_q     <= 1'b1;
      sclk_q    <= 1'b0;
      copi_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      hcnt_q    <= hcnt_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      id_q      <= id_d;
      ncs_q     <= ncs_d;
      sclk_q    <= sclk_d;
      copi_q    <= copi_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign done_id = done_id_q;
  assign nCS     = ncs_q;
  assign SCLK    = sclk_q;
  assign COPI    = copi_q;

endmodule

// File: tb/tb_spi_config_master.sv
// Bench for spi_config_master: timeline model checked every cycle, plus a
// register-peripheral model and directed scenarios on two parameter sets.
module tb_spi_config_master;
  import spi_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [1:0] req_valid [2];
  logic [6:0] req_addr0 [2], req_addr1 [2];
  logic [7:0] req_data0 [2], req_data1 [2];
  logic [1:0] req_ready [2];
  logic       busy [2], done [2], done_id [2], ncs [2], sclk [2], copi [2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [1:0] rr(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : u
    localparam int D = (gi == 0) ? 4 : 3;
    localparam int G = (gi == 0) ? 8 : 4;

    spi_config_master #(.CLK_DIV(D), .GAP_CYCLES(G)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid[gi]),
      .req_addr0(req_addr0[gi]),
      .req_addr1(req_addr1[gi]),
      .req_data0(req_data0[gi]),
      .req_data1(req_data1[gi]),
      .req_ready(req_ready[gi]),
      .busy     (busy[gi]),
      .done     (done[gi]),
      .done_id  (done_id[gi]),
      .nCS      (ncs[gi]),
      .SCLK     (sclk[gi]),
      .COPI     (copi[gi])
    );

    // Model: a frame is a fixed timeline measured from the accepting edge.
    bit          m_on = 1'b0;
    bit          m_active = 1'b0;
    logic        m_last = 1'b1;
    logic        m_id = 1'b0;
    logic [15:0] m_frame = '0;
    int          m_cyc = 0;
    int          m_start = 0;

    always @(posedge clk) begin
      logic [1:0] g;
      if (rst) begin
        m_on = 1'b1; m_active = 1'b0; m_last = 1'b1;
      end else if (m_on && (!m_active || (m_cyc - m_start) >= 33*D + G) && |req_valid[gi]) begin
        g = rr(req_valid[gi], m_last);
        m_last   = g[1];
        m_id     = g[1];
        m_frame  = g[1] ? {1'b1, req_addr1[gi], req_data1[gi]} : {1'b1, req_addr0[gi], req_data0[gi]};
        m_active = 1'b1;
        m_start  = m_cyc + 1;
      end
      m_cyc++;
    end

    always @(negedge clk) begin
      int k, b, ph, idx;
      bit idle, inf;
      logic e_ncs, e_sclk, e_copi, e_done;
      if (m_on) begin
        k      = m_cyc - m_start;
        idle   = !m_active || k >= 33*D + G;
        inf    = m_active && k < 33*D;
        e_ncs  = !inf;
        e_sclk = 1'b0;
        e_copi = 1'b0;
        e_done = m_active && k == 33*D;
        if (inf) begin
          if (k < D) e_copi = m_frame[15];
          else begin
            b   = (k - D) / (2*D);
            ph  = (k - D) % (2*D);
            idx = (ph < D) ? 15 - b : 14 - b;
            e_sclk = (ph < D);
            e_copi = (idx >= 0) ? m_frame[idx[3:0]] : 1'b0;
          end
        end
        chk($sformatf("u%0d.nCS", gi), ncs[gi], e_ncs);
        chk($sformatf("u%0d.SCLK", gi), sclk[gi], e_sclk);
        chk($sformatf("u%0d.COPI", gi), copi[gi], e_copi);
        chk($sformatf("u%0d.done", gi), done[gi], e_done);
        chk($sformatf("u%0d.busy", gi), busy[gi], !idle);
        chk($sformatf("u%0d.req_ready", gi), req_ready[gi], idle ? rr(req_valid[gi], m_last) : 2'b00);
        if (e_done) chk($sformatf("u%0d.done_id", gi), done_id[gi], m_id);
      end
    end

    // Peripheral: counts SCLK rises under nCS low, commits on nCS rise if complete.
    logic [15:0] p_sh = '0;
    logic [15:0] p_word = '0;
    logic [7:0]  p_regs [8] = '{default: 8'h00};
    logic        p_sclk = 1'b0;
    logic        p_ncs = 1'b1;
    int          p_cnt = 0;
    int          p_run = 0;
    int          p_min_gap = 100000;
    bit          p_seen = 1'b0;
    int          p_lens [$];
    int          p_ids [$];

    always @(negedge clk) begin
      if (!ncs[gi] && sclk[gi] && !p_sclk) begin
        p_sh = {p_sh[14:0], copi[gi]};
        p_cnt++;
      end
      if (done[gi]) p_ids.push_back(int'(done_id[gi]));
      if (ncs[gi] !== p_ncs) begin
        if (ncs[gi]) begin
          p_lens.push_back(p_run);
          if (p_cnt == 16 && p_sh[15] && p_sh[14:8] >= 7'd1 && p_sh[14:8] <= 7'd5)
            p_regs[p_sh[10:8]] = p_sh[7:0];
          p_word = p_sh;
          p_cnt  = 0;
        end else begin
          if (p_seen && p_run < p_min_gap) p_min_gap = p_run;
          p_seen = 1'b1;
        end
        p_run = 1;
      end else p_run++;
      p_sclk = sclk[gi];
      p_ncs  = ncs[gi];
    end
  end

  task automatic req(input int ui, input int r, input logic [6:0] a, input logic [7:0] d);
    int t;
    if (r == 0) begin req_addr0[ui] = a; req_data0[ui] = d; end
    else        begin req_addr1[ui] = a; req_data1[ui] = d; end
    req_valid[ui][r] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready[ui][r] && t < 3000);
    if (t >= 3000) chk($sformatf("u%0d.r%0d accept timeout", ui, r), t, 0);
    @(posedge clk); #1;
    req_valid[ui][r] = 1'b0;
  endtask

  task automatic wait_idle(input int ui);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (busy[ui] && t < 3000);
    if (t >= 3000) chk($sformatf("u%0d idle timeout", ui), t, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int n0, t;
    logic [7:0] snap [8];
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 2'b00;
      req_addr0[i] = '0; req_addr1[i] = '0;
      req_data0[i] = '0; req_data1[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset nCS", ncs[0], 1);
    chk("reset SCLK", sclk[0], 0);
    chk("reset COPI", copi[0], 0);
    chk("reset busy", busy[0], 0);
    chk("reset done", done[0], 0);
    chk("reset done_id", done_id[0], 0);
    chk("reset req_ready", req_ready[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single write: addr 5, data 0x80.
    n0 = u[0].p_ids.size();
    req(0, 0, DUTY, 8'h80);
    wait_idle(0);
    chk("single word", u[0].p_word, 16'h8580);
    chk("single nCS low", u[0].p_lens[u[0].p_lens.size()-1], 132);
    chk("single done count", u[0].p_ids.size(), n0 + 1);
    chk("single done_id", u[0].p_ids[n0], 0);
    chk("single duty reg", u[0].p_regs[5], 8'h80);

    // Simultaneous requests right after reset.
    do_reset();
    n0 = u[0].p_ids.size();
    fork
      req(0, 0, OUT_7_0, 8'hFF);
      req(0, 1, OUT_15_8, 8'h0F);
    join
    wait_idle(0);
    chk("simul done count", u[0].p_ids.size(), n0 + 2);
    chk("simul first id", u[0].p_ids[n0], 0);
    chk("simul second id", u[0].p_ids[n0+1], 1);
    chk("simul out_7_0", u[0].p_regs[1], 8'hFF);
    chk("simul out_15_8", u[0].p_regs[2], 8'h0F);

    // Continuous requests: four frames alternate.
    n0 = u[0].p_ids.size();
    fork
      begin req(0, 0, OUT_7_0, 8'h11); req(0, 0, OUT_7_0, 8'h22); end
      begin req(0, 1, OUT_15_8, 8'h33); req(0, 1, OUT_15_8, 8'h44); end
    join
    wait_idle(0);
    chk("cont done count", u[0].p_ids.size(), n0 + 4);
    for (int i = 0; i < 4; i++) chk($sformatf("cont id %0d", i), u[0].p_ids[n0+i], i % 2);
    chk("cont out_7_0", u[0].p_regs[1], 8'h22);
    chk("cont out_15_8", u[0].p_regs[2], 8'h44);
    chk("cont gap >= 8", int'(u[0].p_min_gap >= 8), 1);

    // Reset after the 7th SCLK rise of a write to addr 3.
    req(0, 0, PWM_7_0, 8'hAA);
    t = 0;
    while (u[0].p_cnt < 7 && t < 3000) begin @(negedge clk); t++; end
    chk("mid-frame rise count", u[0].p_cnt, 7);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid reset nCS", ncs[0], 1);
    chk("mid reset SCLK", sclk[0], 0);
    chk("mid reset COPI", copi[0], 0);
    chk("mid reset busy", busy[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid reset pwm_7_0 kept", u[0].p_regs[3], 8'h00);
    req(0, 0, PWM_7_0, 8'h5A);
    wait_idle(0);
    chk("post reset pwm_7_0", u[0].p_regs[3], 8'h5A);

    // Invalid address completes but changes nothing.
    for (int i = 0; i < 8; i++) snap[i] = u[0].p_regs[i];
    n0 = u[0].p_ids.size();
    req(0, 0, 7'h7F, 8'h99);
    wait_idle(0);
    chk("invalid word", u[0].p_word, 16'hFF99);
    chk("invalid done count", u[0].p_ids.size(), n0 + 1);
    for (int i = 1; i <= 5; i++) chk($sformatf("invalid reg %0d kept", i), u[0].p_regs[i], snap[i]);

    // Minimum divide / gap instance: back-to-back writes to addr 4 then 5.
    fork
      req(1, 0, PWM_15_8, 8'h12);
      req(1, 1, DUTY, 8'h34);
    join
    wait_idle(1);
    chk("div3 pwm_15_8", u[1].p_regs[4], 8'h12);
    chk("div3 duty", u[1].p_regs[5], 8'h34);
    chk("div3 frames", u[1].p_lens.size(), 2);
    chk("div3 nCS low 1", u[1].p_lens[0], 99);
    chk("div3 nCS low 2", u[1].p_lens[1], 99);
    chk("div3 gap >= 4", int'(u[1].p_min_gap >= 4), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_config_master.md
# spi_config_master

Register-write master that drives the chip's SPI configuration port (nCS/SCLK/COPI) from on-chip logic instead of an external controller. It arbitrates round-robin between two requesters, serialises each accepted (address, data) pair into one 16-bit write frame (bit 15 = 1, address[14:8], data[7:0], MSB first, SPI mode 0), and pulses completion. Its outputs connect directly to the SPI register peripheral, which samples SCLK and COPI through 2-flop synchronisers on the same `clk`.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles; legal range 3..255. The minimum of 3 guarantees the peripheral's 2-flop synchroniser sees every SCLK level.
- `GAP_CYCLES`, default 8: minimum nCS-high time between frames, in `clk` cycles; legal range 4..255.

- `clk` input 1: the single clock for the block.
- `rst` input 1: reset, synchronous and active-high.
- `req_valid` input 2: per-requester write request. Must be held stable until the matching `req_ready` bit is seen.
- `req_addr0`, `req_addr1` input 7 each: target register address for requester 0 / 1.
- `req_data0`, `req_data1` input 8 each: write data for requester 0 / 1.
- `req_ready` output 2: one-hot accept. Combinational: high only in IDLE, and only for the granted requester.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when a frame completes (nCS rising).
- `done_id` output 1: requester index of the completed frame; valid while `done` is high.
- `nCS` output 1: chip select, active low, registered.
- `SCLK` output 1: serial clock, idle low, registered.
- `COPI` output 1: serial data, registered.

## Operation
- States: IDLE → SETUP → SHIFT → GAP → IDLE.
- **IDLE**
  - nCS=1, SCLK=0, COPI=0.
  - When any `req_valid` bit is high, the arbiter grants exactly one requester.
  - Handshake: `req_valid[i] & req_ready[i]` loads the frame `{1'b1, addr_i, data_i}` into the 16-bit shift register and latches `id=i`. The state moves to SETUP.
- **Arbitration**
  - Round-robin with a 1-bit last-grant pointer; the pointer resets to 1, so requester 0 wins first after reset.
  - When both requesters are valid, the one not granted last wins.
  - When only one is valid, it wins regardless of the pointer.
  - The pointer updates only on a completed handshake.
- **SETUP**
  - nCS=0, COPI=frame[15], SCLK=0, held for CLK_DIV cycles. Then go to SHIFT.
- **SHIFT**
  - 16 bits. Each bit is SCLK=1 for CLK_DIV cycles, then SCLK=0 for CLK_DIV cycles.
  - COPI advances to the next bit on the high→low SCLK transition, so data is stable across each rising edge.
  - After the low phase of bit 0, go to GAP.
- **GAP**
  - Entry cycle: nCS=1 and COPI=0; `done`=1 and `done_id`=id on that same cycle.
  - Hold for GAP_CYCLES cycles, then return to IDLE.
- Requests arriving while `busy` are not accepted and must stay asserted; none are lost or reordered.
- Write bit is always 1; the block issues no reads.
- Reset at any point:
  - Next edge: nCS=1, SCLK=0, COPI=0, state IDLE, pointer=1, `done`=0.
  - A partial frame is abandoned. The peripheral drops it because fewer than 16 rising edges were seen.

## Timing
- Reset values: nCS=1, SCLK=0, COPI=0, busy=0, done=0, done_id=0, req_ready=0 (until IDLE sees valid).
- Handshake at edge T0:
  - T0+1: nCS=0; SETUP occupies CLK_DIV cycles.
  - First SCLK rise at T0+1+CLK_DIV.
  - nCS low for exactly 33·CLK_DIV cycles (132 at the default).
  - nCS rises at T0+1+33·CLK_DIV; `done` is high that cycle.
  - Earliest next handshake: GAP_CYCLES cycles after the nCS rise.
  - Request-to-request period at defaults: 1+132+8 = 141 cycles.
- Exactly 16 SCLK rising edges per frame. SCLK is low whenever nCS changes.
- Counters:
  - 8-bit half-period counter: 0..CLK_DIV-1, wraps on a phase toggle.
  - 5-bit bit counter: 0..15.
  - 8-bit gap counter.
  - No other arithmetic.

## Structure
- Shared package `spi_ctrl_pkg` contains:
  - FRAME_W=16 and WRITE_BIT position 15.
  - Register address constants: OUT_7_0=1, OUT_15_8=2, PWM_7_0=3, PWM_15_8=4, DUTY=5.
  - The state enum {IDLE, SETUP, SHIFT, GAP}.
  - The peripheral and test benches use the same address constants.
- Sub-module `spi_rr_arbiter`: 2-way round-robin with valid in, grant out, update-on-accept, and a pointer. The FSM, shifter and counters live in the top module.

## Test plan
- **Single write:** requester 0 sends addr=5, data=0x80.
  - COPI sampled on the 16 SCLK rises = 1_0000101_10000000.
  - nCS low 132 cycles; `done`=1 and `done_id`=0 at nCS rise.
  - Peripheral model: `pwm_duty_cycle`=0x80.
- **Simultaneous requests:** both valid at the same cycle after reset (r0: addr 1/0xFF, r1: addr 2/0x0F).
  - r0 is served first, then r1; `done_id` sequence 0,1.
  - Peripheral: out_7_0=0xFF, out_15_8=0x0F.
- **Continuous requests:** both requesters held valid for 4 frames.
  - Grants alternate 0,1,0,1.
  - nCS-high gap between frames ≥8 cycles; no request dropped.
- **Reset mid-frame:** assert `rst` after the 7th SCLK rise of a write to addr 3.
  - Next cycle: nCS=1, SCLK=0, COPI=0, busy=0.
  - Peripheral `en_reg_pwm_7_0` is unchanged; the following clean write succeeds.
- **CLK_DIV=3, GAP_CYCLES=4:** back-to-back writes to addr 4 then 5.
  - nCS low 99 cycles each.
  - Peripheral captures both values, confirming the synchroniser margin at the minimum divide.
- **Invalid address:** write addr 0x7F.
  - Frame completes with `done`=1.
  - All peripheral registers are unchanged.
